// File: rtl/mem_refill_arbiter_pkg.sv
// Shared definitions for the memory refill arbiter and the caches it serves.
// Covers the burst FSM state encoding, the owner encoding and the line geometry.
package mem_refill_arbiter_pkg;

  localparam int unsigned LINE_WORDS = 8;
  localparam int unsigned WORD_IDX_W = $clog2(LINE_WORDS);
  // Byte offset of a word within a line: word index plus the 2 byte-lane bits
  localparam int unsigned LINE_OFF_W = WORD_IDX_W + 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant decision between the I-cache and D-cache refill requests.
// MEM_ARB_RR_EN selects round-robin on collisions; otherwise the D-cache always wins.
module mem_arb_pick
  import mem_refill_arbiter_pkg::*;
(
  input  logic   ic_req_i,
  input  logic   dc_req_i,
  input  owner_e last_owner_i,
  output logic   gnt_o,
  output owner_e gnt_owner_o
);

  assign gnt_o = ic_req_i | dc_req_i;

  always_comb begin
    gnt_owner_o = OWN_IC;
    if (ic_req_i && dc_req_i) begin
`ifdef MEM_ARB_RR_EN
      // On a collision the requester that was not served last goes first
      gnt_owner_o = (last_owner_i == OWN_DC) ? OWN_IC : OWN_DC;
`else
      gnt_owner_o = OWN_DC;
`endif
    end else if (dc_req_i) begin
      gnt_owner_o = OWN_DC;
    end
  end

`ifndef MEM_ARB_RR_EN
  logic unused_last_owner;
  assign unused_last_owner = last_owner_i;
`endif

endmodule

// File: rtl/mem_refill_arbiter.sv
// Serialises whole-line bursts from the I-cache and D-cache onto one memory word port.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of fixed D-cache priority.
module mem_refill_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LINE_WORDS = mem_refill_arbiter_pkg::LINE_WORDS,
  parameter int unsigned WORD_IDX_W = $clog2(LINE_WORDS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ic_req,
  input  logic [ADDR_W-1:0]     ic_addr,
  output logic [31:0]           ic_rdata,
  output logic                  ic_rvalid,
  output logic                  ic_done,
  input  logic                  dc_req,
  input  logic                  dc_we,
  input  logic [ADDR_W-1:0]     dc_addr,
  input  logic [31:0]           dc_wdata,
  output logic [WORD_IDX_W-1:0] dc_word,
  output logic [31:0]           dc_rdata,
  output logic                  dc_rvalid,
  output logic                  dc_done,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready
);
  import mem_refill_arbiter_pkg::*;

  localparam int unsigned OffW = WORD_IDX_W + 2;

  state_e                state_q, state_d;
  logic [WORD_IDX_W-1:0] cnt_q, cnt_d;
  owner_e                owner_q, owner_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic                  we_q, we_d;
  logic [31:0]           ic_rdata_q, ic_rdata_d, dc_rdata_q, dc_rdata_d;
  logic                  ic_rvalid_q, ic_rvalid_d, dc_rvalid_q, dc_rvalid_d;

  logic   gnt;
  owner_e gnt_owner;
  owner_e last_owner;
  logic   last_word;

  assign last_word = (cnt_q == WORD_IDX_W'(LINE_WORDS - 1));

`ifdef MEM_ARB_RR_EN
  owner_e last_owner_q, last_owner_d;

  assign last_owner_d = (state_q == ST_DONE) ? owner_q : last_owner_q;
  assign last_owner   = last_owner_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_owner_q <= OWN_IC;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end
`else
  assign last_owner = OWN_IC;
`endif

  mem_arb_pick u_pick (
    .ic_req_i     (ic_req),
    .dc_req_i     (dc_req),
    .last_owner_i (last_owner),
    .gnt_o        (gnt),
    .gnt_owner_o  (gnt_owner)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      owner_q     <= OWN_IC;
      base_q      <= '0;
      we_q        <= 1'b0;
      ic_rdata_q  <= '0;
      dc_rdata_q  <= '0;
      ic_rvalid_q <= 1'b0;
      dc_rvalid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      base_q      <= base_d;
      we_q        <= we_d;
      ic_rdata_q  <= ic_rdata_d;
      dc_rdata_q  <= dc_rdata_d;
      ic_rvalid_q <= ic_rvalid_d;
      dc_rvalid_q <= dc_rvalid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    base_d  = base_q;
    we_d    = we_q;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt) begin
          owner_d = gnt_owner;
          cnt_d   = '0;
          state_d = ST_BURST;
          if (gnt_owner == OWN_DC) begin
            base_d = {dc_addr[ADDR_W-1:OffW], {OffW{1'b0}}};
            we_d   = dc_we;
          end else begin
            base_d = {ic_addr[ADDR_W-1:OffW], {OffW{1'b0}}};
            we_d   = 1'b0;
          end
        end
      end
      ST_BURST: begin
        // Counter parks on the last index; only IDLE rewinds it
        if (mem_ready) begin
          if (last_word) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + WORD_IDX_W'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ic_rdata_d  = ic_rdata_q;
    dc_rdata_d  = dc_rdata_q;
    ic_rvalid_d = 1'b0;
    dc_rvalid_d = 1'b0;
    if ((state_q == ST_BURST) && mem_ready && !we_q) begin
      if (owner_q == OWN_DC) begin
        dc_rdata_d  = mem_rdata;
        dc_rvalid_d = 1'b1;
      end else begin
        ic_rdata_d  = mem_rdata;
        ic_rvalid_d = 1'b1;
      end
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    dc_word   = '0;
    ic_done   = 1'b0;
    dc_done   = 1'b0;
    unique case (state_q)
      ST_BURST: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = base_q | (ADDR_W'(cnt_q) << 2);
        mem_wdata = dc_wdata;
        dc_word   = (owner_q == OWN_DC) ? cnt_q : '0;
      end
      ST_DONE: begin
        ic_done = (owner_q == OWN_IC);
        dc_done = (owner_q == OWN_DC);
      end
      default: ;
    endcase
  end

  assign ic_rdata  = ic_rdata_q;
  assign dc_rdata  = dc_rdata_q;
  assign ic_rvalid = ic_rvalid_q;
  assign dc_rvalid = dc_rvalid_q;

  logic unused_addr_lo;
  assign unused_addr_lo = ^{ic_addr[OffW-1:0], dc_addr[OffW-1:0]};

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Scoreboard bench for mem_refill_arbiter: expected accesses, read data and done pulses
// are queued when a request is issued and retired as the DUT produces them.
module tb_mem_refill_arbiter;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned LINE_WORDS = 8;
  localparam int unsigned WORD_IDX_W = 3;
`ifdef MEM_ARB_RR_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  ic_req, dc_req, dc_we;
  logic [ADDR_W-1:0]     ic_addr, dc_addr;
  logic [31:0]           ic_rdata, dc_rdata, dc_wdata;
  logic                  ic_rvalid, ic_done, dc_rvalid, dc_done;
  logic [WORD_IDX_W-1:0] dc_word;
  logic                  mem_req, mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata = '0;
  logic                  mem_ready = 1'b0;

  assign dc_wdata = 32'hA0 + 32'(dc_word);

  mem_refill_arbiter #(
    .ADDR_W     (ADDR_W),
    .LINE_WORDS (LINE_WORDS),
    .WORD_IDX_W (WORD_IDX_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ic_req    (ic_req),
    .ic_addr   (ic_addr),
    .ic_rdata  (ic_rdata),
    .ic_rvalid (ic_rvalid),
    .ic_done   (ic_done),
    .dc_req    (dc_req),
    .dc_we     (dc_we),
    .dc_addr   (dc_addr),
    .dc_wdata  (dc_wdata),
    .dc_word   (dc_word),
    .dc_rdata  (dc_rdata),
    .dc_rvalid (dc_rvalid),
    .dc_done   (dc_done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic        is_dc;
    int          idx;
  } acc_t;
  typedef struct {
    logic        is_dc;
    logic [31:0] data;
  } rd_t;
  typedef struct {
    logic is_dc;
    logic is_read;
  } done_t;

  acc_t        acc_q[$];
  rd_t         rd_q[$];
  done_t       done_q[$];
  logic [31:0] mem[logic [31:0]];

  int          n_total = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          last_done_cyc = 0;
  int          last_len = 0;
  int          last_gap = 0;
  int          ph = 0;
  bit          req_prev = 1'b0;
  bit          hold_vld = 1'b0;
  bit          stall_mode = 1'b0;
  logic [31:0] hold_addr = '0;
  logic        tb_last = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'hC0DE_0000 ^ a;
  endfunction

  // rd_mode 1: the line is expected to hold 0xA0+word from an earlier writeback
  task automatic expect_burst(input logic is_dc, input logic we, input logic [31:0] base,
                              input bit rd_mode);
    acc_t  a;
    rd_t   r;
    done_t d;
    for (int i = 0; i < int'(LINE_WORDS); i++) begin
      a.addr  = base + 32'(4 * i);
      a.we    = we;
      a.is_dc = is_dc;
      a.idx   = i;
      acc_q.push_back(a);
      if (!we) begin
        r.is_dc = is_dc;
        r.data  = rd_mode ? 32'hA0 + 32'(i) : mem_rd(a.addr);
        rd_q.push_back(r);
      end
    end
    d.is_dc   = is_dc;
    d.is_read = !we;
    done_q.push_back(d);
  endtask

  task automatic flush_sb();
    acc_q.delete();
    rd_q.delete();
    done_q.delete();
    hold_vld = 1'b0;
  endtask

  task automatic wait_done(input logic is_dc);
    bit seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (is_dc ? dc_done : ic_done) begin
        seen = 1'b1;
        break;
      end
    end
    #1;
    if (!seen) begin
      check_eq("done_timeout", 32'd0, 32'd1);
      flush_sb();
    end else begin
      tb_last = is_dc;
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory model and output monitor; mem_ready/mem_rdata set here for the next rising edge
  initial forever begin
    rd_t   r;
    acc_t  a;
    done_t d;
    @(negedge clk);
    if (ic_rvalid || dc_rvalid) begin
      check_eq("rv_both", 32'(ic_rvalid & dc_rvalid), 32'd0);
      if (rd_q.size() == 0) begin
        check_eq("rv_extra", 32'd1, 32'd0);
      end else begin
        r = rd_q.pop_front();
        check_eq("rv_owner", 32'(dc_rvalid), 32'(r.is_dc));
        check_eq("rdata", r.is_dc ? dc_rdata : ic_rdata, r.data);
      end
    end
    if (ic_done || dc_done) begin
      if (done_q.size() == 0) begin
        check_eq("done_extra", 32'd1, 32'd0);
      end else begin
        d = done_q.pop_front();
        check_eq("done_owner", 32'(dc_done), 32'(d.is_dc));
        check_eq("done_both", 32'(ic_done & dc_done), 32'd0);
        if (d.is_read) check_eq("done_with_rv", 32'(d.is_dc ? dc_rvalid : ic_rvalid), 32'd1);
      end
      last_len      = cyc - start_cyc;
      last_done_cyc = cyc;
    end
    if (mem_req && !req_prev) begin
      last_gap  = cyc - last_done_cyc;
      start_cyc = cyc;
    end
    req_prev = mem_req;
    if (mem_req && hold_vld) check_eq("stall_hold", mem_addr, hold_addr);
    mem_ready = stall_mode ? ((ph % 3) == 0) : 1'b1;
    if (mem_req) ph++;
    mem_rdata = mem_rd(mem_addr);
    if (mem_req && mem_ready) begin
      if (acc_q.size() == 0) begin
        check_eq("acc_extra", 32'd1, 32'd0);
      end else begin
        a = acc_q.pop_front();
        check_eq("mem_addr", mem_addr, a.addr);
        check_eq("mem_we", 32'(mem_we), 32'(a.we));
        check_eq("dc_word", 32'(dc_word), a.is_dc ? 32'(a.idx) : 32'd0);
        if (a.we) begin
          check_eq("mem_wdata", mem_wdata, 32'hA0 + 32'(a.idx));
          mem[mem_addr] = mem_wdata;
        end
      end
    end
    hold_vld  = mem_req && !mem_ready;
    hold_addr = mem_addr;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit   found;
    logic win_dc;
    reset   = 1'b1;
    ic_req  = 1'b0;
    dc_req  = 1'b0;
    dc_we   = 1'b0;
    ic_addr = '0;
    dc_addr = '0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_mem_req", 32'(mem_req), 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_done", 32'({ic_done, dc_done}), 32'd0);
    check_eq("rst_rvalid", 32'({ic_rvalid, dc_rvalid}), 32'd0);
    check_eq("rst_rdata", ic_rdata | dc_rdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // I-cache refill, unaligned miss address
    expect_burst(1'b0, 1'b0, 32'h0040_0100, 1'b0);
    ic_addr = 32'h0040_0104;
    ic_req  = 1'b1;
    wait_done(1'b0);
    ic_req = 1'b0;
    check_eq("ic_burst_len", 32'(last_len), 32'd8);
    repeat (3) @(negedge clk);

    // D-cache writeback
    expect_burst(1'b1, 1'b1, 32'h0050_0100, 1'b0);
    dc_we   = 1'b1;
    dc_addr = 32'h0050_0110;
    dc_req  = 1'b1;
    wait_done(1'b1);
    dc_req = 1'b0;
    dc_we  = 1'b0;
    repeat (3) @(negedge clk);

    // Two colliding pairs
    for (int k = 0; k < 2; k++) begin
      win_dc = RrEn ? (tb_last == 1'b0) : 1'b1;
      if (win_dc) begin
        expect_burst(1'b1, 1'b0, 32'h0040_0100, 1'b0);
        expect_burst(1'b0, 1'b0, 32'h0060_0100, 1'b0);
      end else begin
        expect_burst(1'b0, 1'b0, 32'h0060_0100, 1'b0);
        expect_burst(1'b1, 1'b0, 32'h0040_0100, 1'b0);
      end
      ic_addr = 32'h0060_0100;
      dc_addr = 32'h0040_0100;
      dc_we   = 1'b0;
      ic_req  = 1'b1;
      dc_req  = 1'b1;
      wait_done(win_dc);
      if (win_dc) dc_req = 1'b0;
      else ic_req = 1'b0;
      wait_done(!win_dc);
      ic_req = 1'b0;
      dc_req = 1'b0;
      check_eq("pair_gap", 32'(last_gap), 32'd2);
      repeat (3) @(negedge clk);
    end

    // D-cache refill with 1,0,0 ready pattern
    stall_mode = 1'b1;
    ph         = 0;
    expect_burst(1'b1, 1'b0, 32'h0070_0100, 1'b0);
    dc_addr = 32'h0070_0100;
    dc_req  = 1'b1;
    wait_done(1'b1);
    dc_req     = 1'b0;
    stall_mode = 1'b0;
    check_eq("stall_burst_len", 32'(last_len), 32'd22);
    repeat (3) @(negedge clk);

    // Eviction: writeback then refill back to back, then read the victim line back
    expect_burst(1'b1, 1'b1, 32'h0050_0100, 1'b0);
    expect_burst(1'b1, 1'b0, 32'h0060_0100, 1'b0);
    dc_we   = 1'b1;
    dc_addr = 32'h0050_0100;
    dc_req  = 1'b1;
    wait_done(1'b1);
    dc_we   = 1'b0;
    dc_addr = 32'h0060_0100;
    wait_done(1'b1);
    dc_req = 1'b0;
    check_eq("evict_gap", 32'(last_gap), 32'd2);
    repeat (3) @(negedge clk);
    expect_burst(1'b1, 1'b0, 32'h0050_0100, 1'b1);
    dc_addr = 32'h0050_0100;
    dc_req  = 1'b1;
    wait_done(1'b1);
    dc_req = 1'b0;
    repeat (3) @(negedge clk);

    // Reset during word 3 of an I-cache burst
    expect_burst(1'b0, 1'b0, 32'h0040_0100, 1'b0);
    ic_addr = 32'h0040_0100;
    ic_req  = 1'b1;
    found   = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mem_req && (mem_addr == 32'h0040_010C)) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("rst_word3_seen", 32'(found), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("rst_async_mem_req", 32'(mem_req), 32'd0);
    check_eq("rst_async_rvalid", 32'(ic_rvalid), 32'd0);
    flush_sb();
    ic_req  = 1'b0;
    tb_last = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    expect_burst(1'b0, 1'b0, 32'h0040_0100, 1'b0);
    ic_req = 1'b1;
    wait_done(1'b0);
    ic_req = 1'b0;
    check_eq("restart_burst_len", 32'(last_len), 32'd8);

    repeat (4) @(negedge clk);
    check_eq("sb_empty", 32'(acc_q.size() + rd_q.size() + done_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
